// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V controller: opcodes, FSM states and
// the datapath select encodings.
package riscv_pkg;

  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_B    = 7'd99;
  localparam logic [6:0] OP_LUI  = 7'd55;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StJalr,
    StJalrPc,
    StBranch,
    StLui,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmJ = 3'b011,
    ImmU = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARd1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SrcBRd2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    AluOpAdd    = 2'b00,
    AluOpBranch = 2'b01,
    AluOpRFunct = 2'b10,
    AluOpIFunct = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResMemData   = 2'b01,
    ResAluResult = 2'b10,
    ResImm       = 2'b11
  } result_src_e;

endpackage

// File: rtl/controller_multi_cycle_imm_decode.sv
// Combinational opcode to immediate-format decoder; shared with the single-cycle core.
module controller_multi_cycle_imm_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = ImmI;
    case (opcode_i)
      OP_SW:   imm_src_o = ImmS;
      OP_B:    imm_src_o = ImmB;
      OP_JAL:  imm_src_o = ImmJ;
      OP_LUI:  imm_src_o = ImmU;
      default: imm_src_o = ImmI;
    endcase
  end

endmodule

// File: rtl/controller_multi_cycle.sv
// Main FSM of the multi-cycle core: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and unified memory, and counts retired instructions.
module controller_multi_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 adr_src_o,
  output logic                 mem_write_o,
  output logic                 ir_write_o,
  output logic                 reg_write_o,
  output logic [2:0]           imm_src_o,
  output logic [1:0]           alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic [1:0]           result_src_o,
  output logic                 branch_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_count_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic pc_write, adr_src, mem_write, ir_write, reg_write, branch, illegal;

  controller_multi_cycle_imm_decode u_imm_decode (
    .opcode_i  (opcode_i),
    .imm_src_o (imm_src_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecR;
          OP_I:         state_d = StExecI;
          OP_JAL:       state_d = StJal;
          OP_JALR:      state_d = StJalr;
          OP_B:         state_d = StBranch;
          OP_LUI:       state_d = StLui;
          default:      state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode_i == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready_i) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready_i) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StJalrPc;
      StJalrPc:   state_d = StAluWb;
      StBranch:   state_d = StFetch;
      StLui:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Every return to FETCH from another state completes one instruction; TRAP never returns.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StFetch && state_q != StFetch) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    pc_write     = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    branch       = 1'b0;
    illegal      = 1'b0;
    alu_src_a_o  = SrcAPc;
    alu_src_b_o  = SrcBRd2;
    alu_op_o     = AluOpAdd;
    result_src_o = ResAluOut;
    unique case (state_q)
      StFetch: begin
        alu_src_b_o  = SrcBFour;
        result_src_o = ResAluResult;
        ir_write     = mem_ready_i;
        pc_write     = mem_ready_i;
      end
      StDecode: begin
        alu_src_a_o = SrcAOldPc;
        alu_src_b_o = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a_o = SrcARd1;
        alu_src_b_o = SrcBImm;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src_o = ResMemData;
        reg_write    = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a_o = SrcARd1;
        alu_op_o    = AluOpRFunct;
      end
      StExecI: begin
        alu_src_a_o = SrcARd1;
        alu_src_b_o = SrcBImm;
        alu_op_o    = AluOpIFunct;
      end
      StAluWb:    reg_write = 1'b1;
      StJal, StJalrPc: begin
        alu_src_a_o = SrcAOldPc;
        alu_src_b_o = SrcBFour;
        pc_write    = 1'b1;
      end
      StJalr: begin
        alu_src_a_o = SrcARd1;
        alu_src_b_o = SrcBImm;
      end
      StBranch: begin
        alu_src_a_o = SrcARd1;
        alu_op_o    = AluOpBranch;
        branch      = 1'b1;
      end
      StLui: begin
        result_src_o = ResImm;
        reg_write    = 1'b1;
      end
      StTrap:     illegal = 1'b1;
      default:    ;
    endcase
  end

  // Reset gates the enables directly so none can pulse while the state register clears.
  assign pc_write_o      = pc_write  & ~rst;
  assign adr_src_o       = adr_src;
  assign mem_write_o     = mem_write & ~rst;
  assign ir_write_o      = ir_write  & ~rst;
  assign reg_write_o     = reg_write & ~rst;
  assign branch_o        = branch    & ~rst;
  assign illegal_o       = illegal   & ~rst;
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_controller_multi_cycle.sv
// Directed bench for controller_multi_cycle: each cycle's expected outputs are queued as the
// inputs are driven and compared at the following falling edge.
module tb_controller_multi_cycle;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write, branch, illegal;
  logic [2:0]    imm_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic [CW-1:0] retired_count;

  typedef struct packed {
    logic          pcw;
    logic          adr;
    logic          memw;
    logic          irw;
    logic          regw;
    logic [2:0]    imm;
    logic [1:0]    a;
    logic [1:0]    b;
    logic [1:0]    op;
    logic [1:0]    res;
    logic          br;
    logic          ill;
    logic [CW-1:0] cnt;
  } out_t;

  typedef enum {
    PhRst, PhFetch, PhDecode, PhMemAdr, PhMemRead, PhMemWb, PhMemWrite, PhExecR, PhExecI,
    PhAluWb, PhJal, PhJalr, PhJalrPc, PhBranch, PhLui, PhTrap
  } ph_e;

  out_t          sb_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  controller_multi_cycle #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .adr_src_o       (adr_src),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .reg_write_o     (reg_write),
    .imm_src_o       (imm_src),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .result_src_o    (result_src),
    .branch_o        (branch),
    .illegal_o       (illegal),
    .retired_count_o (retired_count)
  );

  function automatic logic [2:0] ref_imm(input logic [6:0] opc);
    case (opc)
      7'd35:   return 3'b001;
      7'd99:   return 3'b010;
      7'd111:  return 3'b011;
      7'd55:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic out_t expect_out(input ph_e p, input logic rdy);
    out_t o;
    o     = '0;
    o.imm = ref_imm(opcode);
    o.cnt = exp_cnt;
    case (p)
      PhRst:      begin o.b = 2'b10; o.res = 2'b10; end
      PhFetch:    begin o.b = 2'b10; o.res = 2'b10; o.pcw = rdy; o.irw = rdy; end
      PhDecode:   begin o.a = 2'b01; o.b = 2'b01; end
      PhMemAdr:   begin o.a = 2'b10; o.b = 2'b01; end
      PhMemRead:  o.adr = 1'b1;
      PhMemWb:    begin o.res = 2'b01; o.regw = 1'b1; end
      PhMemWrite: begin o.adr = 1'b1; o.memw = 1'b1; end
      PhExecR:    begin o.a = 2'b10; o.op = 2'b10; end
      PhExecI:    begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b11; end
      PhAluWb:    o.regw = 1'b1;
      PhJal:      begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; end
      PhJalr:     begin o.a = 2'b10; o.b = 2'b01; end
      PhJalrPc:   begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; end
      PhBranch:   begin o.a = 2'b10; o.op = 2'b01; o.br = 1'b1; end
      PhLui:      begin o.res = 2'b11; o.regw = 1'b1; end
      PhTrap:     o.ill = 1'b1;
      default:    ;
    endcase
    return o;
  endfunction

  // Drive one cycle's inputs, queue what that cycle must show, check at the falling edge.
  task automatic step(input string tag, input logic [6:0] opc, input logic rdy, input ph_e p);
    out_t got, e;
    opcode    = opc;
    mem_ready = rdy;
    sb_q.push_back(expect_out(p, rdy));
    @(negedge clk);
    got = {pc_write, adr_src, mem_write, ir_write, reg_write, imm_src, alu_src_a, alu_src_b,
           alu_op, result_src, branch, illegal, retired_count};
    e = sb_q.pop_front();
    n_vec++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_cnt = exp_cnt + CW'(1);
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 7'd51;
    mem_ready = 1'b0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    step("rst_idle", 7'd51, 1'b0, PhRst);
    step("rst_ready_gated", 7'd51, 1'b1, PhRst);
    rst = 1'b0;

    step("r_fetch", 7'd51, 1'b1, PhFetch);
    step("r_decode", 7'd51, 1'b1, PhDecode);
    step("r_exec", 7'd51, 1'b1, PhExecR);
    step("r_wb", 7'd51, 1'b1, PhAluWb);
    retire();

    step("lw_fetch_wait", 7'd3, 1'b0, PhFetch);
    step("lw_fetch", 7'd3, 1'b1, PhFetch);
    step("lw_decode", 7'd3, 1'b0, PhDecode);
    step("lw_memadr", 7'd3, 1'b0, PhMemAdr);
    step("lw_read_w0", 7'd3, 1'b0, PhMemRead);
    step("lw_read_w1", 7'd3, 1'b0, PhMemRead);
    step("lw_read", 7'd3, 1'b1, PhMemRead);
    step("lw_wb", 7'd3, 1'b0, PhMemWb);
    retire();

    step("sw_fetch", 7'd35, 1'b1, PhFetch);
    step("sw_decode", 7'd35, 1'b0, PhDecode);
    step("sw_memadr", 7'd35, 1'b0, PhMemAdr);
    step("sw_write_w0", 7'd35, 1'b0, PhMemWrite);
    step("sw_write_w1", 7'd35, 1'b0, PhMemWrite);
    step("sw_write", 7'd35, 1'b1, PhMemWrite);
    retire();

    step("jalr_fetch", 7'd103, 1'b1, PhFetch);
    step("jalr_decode", 7'd103, 1'b1, PhDecode);
    step("jalr_target", 7'd103, 1'b1, PhJalr);
    step("jalr_pc", 7'd103, 1'b1, PhJalrPc);
    step("jalr_wb", 7'd103, 1'b1, PhAluWb);
    retire();

    step("beq_fetch", 7'd99, 1'b1, PhFetch);
    step("beq_decode", 7'd99, 1'b1, PhDecode);
    step("beq_branch", 7'd99, 1'b1, PhBranch);
    retire();
    step("beq_branch_once", 7'd111, 1'b1, PhFetch);

    step("jal_decode", 7'd111, 1'b1, PhDecode);
    step("jal_pc", 7'd111, 1'b1, PhJal);
    step("jal_wb", 7'd111, 1'b1, PhAluWb);
    retire();

    step("i_fetch", 7'd19, 1'b1, PhFetch);
    step("i_decode", 7'd19, 1'b1, PhDecode);
    step("i_exec", 7'd19, 1'b1, PhExecI);
    step("i_wb", 7'd19, 1'b1, PhAluWb);
    retire();

    // Reset lands in the middle of a store that is still waiting on memory.
    step("swr_fetch", 7'd35, 1'b1, PhFetch);
    step("swr_decode", 7'd35, 1'b0, PhDecode);
    step("swr_memadr", 7'd35, 1'b0, PhMemAdr);
    step("swr_write_w0", 7'd35, 1'b0, PhMemWrite);
    rst     = 1'b1;
    exp_cnt = '0;
    step("rst_mid_write", 7'd35, 1'b0, PhRst);
    rst = 1'b0;
    step("post_rst_fetch_wait", 7'd55, 1'b0, PhFetch);

    for (int i = 0; i < 16; i++) begin
      step("lui_fetch", 7'd55, 1'b1, PhFetch);
      step("lui_decode", 7'd55, 1'b1, PhDecode);
      step("lui_wb", 7'd55, 1'b1, PhLui);
      retire();
    end

    step("trap_fetch_wrapped", 7'h7F, 1'b1, PhFetch);
    step("trap_decode", 7'h7F, 1'b1, PhDecode);
    step("trap_0", 7'h7F, 1'b1, PhTrap);
    step("trap_1", 7'h7F, 1'b0, PhTrap);
    step("trap_2", 7'd51, 1'b1, PhTrap);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
